// File: rtl/morse_char_framer_if.sv
// Symbol-in / character-out bus of the Morse character framer.
// master = framer side, slave = detector plus downstream decoder side.
interface morse_char_framer_if #(
  parameter int MAX_SYMS = 5
);
  logic                sample_tick;
  logic [1:0]          sym_in;
  logic                sym_valid;
  logic [MAX_SYMS-1:0] char_bits;
  logic [2:0]          char_len;
  logic                char_err;
  logic                char_valid;
  logic                char_ready;
  logic                overrun;
  logic                clr_overrun;

  modport master (
    output sample_tick, char_bits, char_len, char_err, char_valid, overrun,
    input  sym_in, sym_valid, char_ready, clr_overrun
  );

  modport slave (
    input  sample_tick, char_bits, char_len, char_err, char_valid, overrun,
    output sym_in, sym_valid, char_ready, clr_overrun
  );
endinterface

// File: rtl/morse_char_framer.sv
// Paces the Morse symbol detector with a unit-time strobe and packs its dot/dash
// stream into character frames handed downstream over valid/ready.
module morse_char_framer #(
  parameter int TICK_DIV   = 5000000,
  parameter int MAX_SYMS   = 5,
  parameter int IDLE_TICKS = 7
) (
  input  logic clk,
  input  logic rst,
  morse_char_framer_if.master bus
);

  localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

  typedef enum logic [1:0] {EMPTY, ACCUM, OVF} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [MAX_SYMS-1:0] buf_q, buf_d;
  logic [2:0]          len_q, len_d;
  logic                tick;
  logic                is_mark, is_space, is_dash, timeout;
  logic                close;
  logic [MAX_SYMS-1:0] out_bits_q;
  logic [2:0]          out_len_q;
  logic                out_err_q, out_valid_q, overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_q <= '0;
    else if (tick)
      div_q <= '0;
    else
      div_q <= div_q + 1'b1;
  end

  assign tick     = (div_q == DIV_W'(TICK_DIV - 1));
  assign is_mark  = bus.sym_valid && (bus.sym_in == 2'b01 || bus.sym_in == 2'b10);
  assign is_space = bus.sym_valid && (bus.sym_in == 2'b11);
  assign is_dash  = (bus.sym_in == 2'b10);
  // The timeout wins even over a same-cycle symbol; a dot/dash then opens the next frame.
  assign timeout  = (state_q != EMPTY) && tick && (idle_q == IDLE_W'(IDLE_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      len_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    idle_d  = idle_q;
    close   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (is_mark) begin
          buf_d    = '0;
          buf_d[0] = is_dash;
          len_d    = 3'd1;
          idle_d   = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM, OVF: begin
        if (timeout || is_space) begin
          close   = 1'b1;
          buf_d   = '0;
          len_d   = '0;
          idle_d  = '0;
          state_d = EMPTY;
          if (is_mark) begin
            buf_d[0] = is_dash;
            len_d    = 3'd1;
            state_d  = ACCUM;
          end
        end else if (is_mark) begin
          idle_d = '0;
          if (state_q == ACCUM && len_q < 3'(MAX_SYMS)) begin
            for (int i = 0; i < MAX_SYMS; i++)
              if (len_q == 3'(i))
                buf_d[i] = is_dash;
            len_d = len_q + 3'd1;
          end else begin
            state_d = OVF;
          end
        end else if (tick) begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Single output slot: a close may refill it in the same cycle it is being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bits_q  <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (close && (!out_valid_q || bus.char_ready)) begin
        out_bits_q  <= buf_q;
        out_len_q   <= len_q;
        out_err_q   <= (state_q == OVF);
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.char_ready) begin
        out_valid_q <= 1'b0;
      end
      if (close && out_valid_q && !bus.char_ready)
        overrun_q <= 1'b1;
      else if (bus.clr_overrun)
        overrun_q <= 1'b0;
    end
  end

  assign bus.sample_tick = tick;
  assign bus.char_bits   = out_bits_q;
  assign bus.char_len    = out_len_q;
  assign bus.char_err    = out_err_q;
  assign bus.char_valid  = out_valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_morse_char_framer.sv
// Scoreboard bench for morse_char_framer: expected frames are queued as symbols are
// driven and matched against each valid/ready handshake.
module tb_morse_char_framer;

  typedef struct packed {
    logic [4:0] bits;
    logic [2:0] len;
    logic       err;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  frame_t expq[$];
  frame_t mon_frame;
  int     ticks;
  logic   prev_tick;
  logic   seen;

  morse_char_framer_if #(.MAX_SYMS(5)) bus();

  morse_char_framer #(
    .TICK_DIV(4),
    .MAX_SYMS(5),
    .IDLE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one symbol for one cycle; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [1:0] sym);
    bus.sym_in    = sym;
    bus.sym_valid = 1'b1;
    @(posedge clk); #1;
    bus.sym_in    = 2'b00;
    bus.sym_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.char_valid && bus.char_ready) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_frame", 1, 0);
      end else begin
        mon_frame = expq.pop_front();
        checkOutput("char_bits", bus.char_bits, mon_frame.bits);
        checkOutput("char_len", bus.char_len, mon_frame.len);
        checkOutput("char_err", bus.char_err, mon_frame.err);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.sym_in      = 2'b00;
    bus.sym_valid   = 1'b0;
    bus.char_ready  = 1'b0;
    bus.clr_overrun = 1'b0;

    // Reset values, then strobe lands on every 4th edge after release.
    #12;
    checkOutput("rst_valid", bus.char_valid, 0);
    checkOutput("rst_len", bus.char_len, 0);
    checkOutput("rst_bits", bus.char_bits, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    checkOutput("rst_tick", bus.sample_tick, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("tick_%0d", k), bus.sample_tick, ((k + 1) % 4 == 0) ? 1 : 0);
    end
    checkOutput("valid_before_frame", bus.char_valid, 0);
    @(posedge clk); #1;

    // Basic frame: dot dash dash, space.
    bus.char_ready = 1'b1;
    expq.push_back('{bits: 5'b00110, len: 3'd3, err: 1'b0});
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    waitDrain();

    // Idle close: dash dot, then the frame must close on the third strobe.
    expq.push_back('{bits: 5'b00001, len: 3'd2, err: 1'b0});
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    ticks = 0;
    prev_tick = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.char_valid) begin
        seen = 1'b1;
      end else begin
        prev_tick = bus.sample_tick;
        if (bus.sample_tick) ticks++;
      end
    end
    checkOutput("idle_seen", seen, 1);
    checkOutput("idle_ticks", ticks, 3);
    checkOutput("idle_on_strobe", prev_tick, 1);
    @(posedge clk); #1;
    waitDrain();

    // Overflow: seven dots then space, followed by a clean dash frame.
    expq.push_back('{bits: 5'b00000, len: 3'd5, err: 1'b1});
    repeat (7) applyStimulus(2'b01);
    applyStimulus(2'b11);
    expq.push_back('{bits: 5'b00001, len: 3'd1, err: 1'b0});
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    waitDrain();

    // Backpressure: frame A held, frame B dropped, overrun set then cleared.
    bus.char_ready = 1'b0;
    expq.push_back('{bits: 5'b00001, len: 3'd2, err: 1'b0});
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    applyStimulus(2'b01);
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    idleCycles(2);
    checkOutput("held_valid", bus.char_valid, 1);
    checkOutput("held_len", bus.char_len, 2);
    checkOutput("held_bits", bus.char_bits, 5'b00001);
    checkOutput("overrun_set", bus.overrun, 1);
    bus.clr_overrun = 1'b1;
    @(posedge clk); #1;
    bus.clr_overrun = 1'b0;
    checkOutput("overrun_clr", bus.overrun, 0);

    // Close coincides with the handshake of A: C must follow without a bubble.
    expq.push_back('{bits: 5'b00011, len: 3'd2, err: 1'b0});
    applyStimulus(2'b10);
    applyStimulus(2'b10);
    bus.char_ready = 1'b1;
    applyStimulus(2'b11);
    checkOutput("b2b_valid", bus.char_valid, 1);
    checkOutput("b2b_bits", bus.char_bits, 5'b00011);
    checkOutput("b2b_overrun", bus.overrun, 0);
    waitDrain();

    // Async reset while a frame is held and another is being built.
    bus.char_ready = 1'b0;
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    checkOutput("pre_rst_valid", bus.char_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_valid", bus.char_valid, 0);
    checkOutput("async_len", bus.char_len, 0);
    checkOutput("async_bits", bus.char_bits, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.char_ready = 1'b1;
    expq.push_back('{bits: 5'b00000, len: 3'd1, err: 1'b0});
    applyStimulus(2'b01);
    applyStimulus(2'b11);
    waitDrain();
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
